// File: rtl/hazard_forward_ctrl_if.sv
// hazard_forward_ctrl_if: pipeline-register fields in, forwarding selects / enables / flushes / counters out.
// master: datapath side (drives pipeline fields, reads controls); slave: hazard controller.
interface hazard_forward_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic             id_uses_rt, ex_regwrite, ex_memread;
    logic             mem_regwrite, mem_access, mem_ready, mem_br_taken, wb_regwrite;
    logic [1:0]       fwd_a, fwd_b;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             wait_err;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_dest, ex_regwrite, ex_memread,
               mem_dest, mem_regwrite, mem_access, mem_ready, mem_br_taken, wb_dest, wb_regwrite,
        input  fwd_a, fwd_b, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, stall_cnt, flush_cnt, wait_err
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_dest, ex_regwrite, ex_memread,
               mem_dest, mem_regwrite, mem_access, mem_ready, mem_br_taken, wb_dest, wb_regwrite,
        output fwd_a, fwd_b, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, stall_cnt, flush_cnt, wait_err
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: operand forwarding, load-use stall, branch flush and data-memory wait freeze.
// Ports: clk, rst_n (async active-low), bus (hazard_forward_ctrl_if.slave).
// Macro HAZ_FORWARD_EN enables forwarding; without it forwarding is 00 and any EX/MEM RAW stalls.
module hazard_forward_ctrl #(
    parameter int          REG_W    = 5,
    parameter int          CNT_W    = 16,
    parameter int unsigned WAIT_MAX = 255
) (
    input logic                 clk,
    input logic                 rst_n,
    hazard_forward_ctrl_if.slave bus
);
    typedef enum logic {RUN, MEMWAIT} state_t;

    state_t           state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             err_q, err_d;
    logic             lu, freeze, br, hold;
    logic [1:0]       fa, fb;

    function automatic logic hit(input logic we, input logic [REG_W-1:0] d, input logic [REG_W-1:0] r);
        return we && d != '0 && d == r;
    endfunction

    function automatic logic src_hit(input logic we, input logic [REG_W-1:0] d);
        return hit(we, d, bus.id_rs) || (bus.id_uses_rt && hit(we, d, bus.id_rt));
    endfunction

`ifdef HAZ_FORWARD_EN
    function automatic logic [1:0] fwd(input logic [REG_W-1:0] r);
        return hit(bus.mem_regwrite, bus.mem_dest, r) ? 2'b10 :
               hit(bus.wb_regwrite, bus.wb_dest, r)   ? 2'b01 : 2'b00;
    endfunction
    assign fa = fwd(bus.ex_rs);
    assign fb = fwd(bus.ex_rt);
    assign lu = src_hit(bus.ex_memread, bus.ex_dest);
`else
    // WB results are written in the first half-cycle, so only EX/MEM producers stall
    assign fa = 2'b00;
    assign fb = 2'b00;
    assign lu = src_hit(bus.ex_regwrite, bus.ex_dest) || src_hit(bus.mem_regwrite, bus.mem_dest);
`endif

    always_comb begin
        // in MEMWAIT only mem_ready matters; the release cycle falls through to branch/lu handling
        freeze  = (state_q == RUN) ? (bus.mem_access && !bus.mem_ready) : !bus.mem_ready;
        br      = !freeze && bus.mem_br_taken;
        hold    = freeze || (!bus.mem_br_taken && lu);
        state_d = freeze ? MEMWAIT : RUN;
        wait_d  = (freeze && state_q == MEMWAIT) ? ((wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1) : 16'd0;
        err_d   = err_q || (wait_d == 16'(WAIT_MAX));
        stall_d = (hold && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        flush_d = (br && flush_q != '1) ? flush_q + 1'b1 : flush_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    // reset forces a free-running pipeline without waiting for a clock edge
    assign bus.fwd_a       = rst_n ? fa : 2'b00;
    assign bus.fwd_b       = rst_n ? fb : 2'b00;
    assign bus.pc_en       = !rst_n || !hold;
    assign bus.ifid_en     = !rst_n || !hold;
    assign bus.idex_en     = !rst_n || !freeze;
    assign bus.exmem_en    = !rst_n || !freeze;
    assign bus.memwb_en    = !rst_n || !freeze;
    assign bus.ifid_flush  = rst_n && br;
    assign bus.exmem_flush = rst_n && br;
    assign bus.idex_flush  = rst_n && !freeze && (bus.mem_br_taken || lu);
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;
    assign bus.wait_err    = err_q;
endmodule
